// File: rtl/seg_display_driver_pkg.sv
// Shared constants for the 7-segment display driver: active-low glyph codes,
// all-off patterns, scan state encoding and the nibble decoder.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   // Nibble F is a deliberate blank glyph so callers can suppress a digit.
   localparam logic [6:0] SEG_F = 7'h7F;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   function automatic logic [6:0] decode_nibble(input logic [3:0] i_nib);
      logic [6:0] w_seg;
      case (i_nib)
         4'h0:    w_seg = SEG_0;
         4'h1:    w_seg = SEG_1;
         4'h2:    w_seg = SEG_2;
         4'h3:    w_seg = SEG_3;
         4'h4:    w_seg = SEG_4;
         4'h5:    w_seg = SEG_5;
         4'h6:    w_seg = SEG_6;
         4'h7:    w_seg = SEG_7;
         4'h8:    w_seg = SEG_8;
         4'h9:    w_seg = SEG_9;
         4'hA:    w_seg = SEG_A;
         4'hB:    w_seg = SEG_B;
         4'hC:    w_seg = SEG_C;
         4'hD:    w_seg = SEG_D;
         4'hE:    w_seg = SEG_E;
         default: w_seg = SEG_F;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/seg_display_driver_sync2.sv
// Generic two-flop synchroniser, asynchronous reset to 0. Shared by the
// stopwatch blocks that take signals from the derived-clock domain.
module sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed common-anode 7-segment driver with per-digit
// decimal point, blink masking and all-off dead time between digits.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | all anodes off for BLANK_CYCLES; snapshot digit idx on exit
//   ST_DRIVE | anode idx on, snapshot glyph shown; advance idx on exit
module seg_display_driver
   import seg_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned REFRESH_HZ   = 1000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  blink_en,
   input  logic        blink,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned DWELL = CLK_HZ / (REFRESH_HZ * 4);
   localparam int unsigned CW    = $clog2(DWELL);

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(DWELL - BLANK_CYCLES - 1);

   if ((DWELL <= BLANK_CYCLES + 1) || (BLANK_CYCLES < 1)) begin : g_bad_timing
      $error("seg_display_driver: DWELL must exceed BLANK_CYCLES+1 and BLANK_CYCLES must be >= 1");
   end

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [3:0]    r_nib;
   logic          r_dp_on;
   logic          r_blink_on;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;

   logic          w_blink_s;
   logic [3:0]    w_nib_sel;
   logic          w_blanked;

   sync2 #(.W(1)) u_blink_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (blink),
      .o_q   (w_blink_s)
   );

   assign w_nib_sel = digits[{r_idx, 2'b00} +: 4];
   // Blink masking uses the live synchronised level, not a snapshot.
   assign w_blanked = r_blink_on && !w_blink_s;

   // Outputs are computed from the current state, so they trail the state
   // register by one edge; this keeps every pin registered with uniform timing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_BLANK;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_nib      <= '0;
         r_dp_on    <= 1'b0;
         r_blink_on <= 1'b0;
         r_an       <= AN_OFF;
         r_seg      <= SEG_OFF;
         r_dp       <= 1'b1;
      end else begin
         case (r_state)
            ST_BLANK: begin
               r_an  <= AN_OFF;
               r_seg <= SEG_OFF;
               r_dp  <= 1'b1;
               if (r_cnt == BLANK_LAST) begin
                  r_cnt      <= '0;
                  r_nib      <= w_nib_sel;
                  r_dp_on    <= dp_mask[r_idx];
                  r_blink_on <= blink_en[r_idx];
                  r_state    <= ST_DRIVE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DRIVE: begin
               r_an <= ~(4'b0001 << r_idx);
               if (w_blanked) begin
                  r_seg <= SEG_OFF;
                  r_dp  <= 1'b1;
               end else begin
                  r_seg <= decode_nibble(r_nib);
                  r_dp  <= ~r_dp_on;
               end
               if (r_cnt == DRIVE_LAST) begin
                  r_cnt   <= '0;
                  r_idx   <= r_idx + 1'b1;
                  r_state <= ST_BLANK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_BLANK;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench: stimulus queues the expected output runs (value + length),
// a monitor collapses DUT output into runs and compares each as it closes.
module tb_seg_display_driver;

   logic        clk;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic [3:0]  blink_en;
   logic        blink;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         len;
   } rec_t;

   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   overlap_viol = 0;
   int   dead_viol = 0;

   seg_display_driver #(
      .CLK_HZ       (40_000),
      .REFRESH_HZ   (1000),
      .BLANK_CYCLES (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .digits   (digits),
      .dp_mask  (dp_mask),
      .blink_en (blink_en),
      .blink    (blink),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      rec_t r;
      r.an  = a;
      r.seg = s;
      r.dp  = d;
      r.len = n;
      exp_q.push_back(r);
   endtask

   task automatic push_off();
      push(4'hF, 7'h7F, 1'b1, 2);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Asynchronous reset response: checked 1 time unit after rst rises.
   initial begin
      rec_t e;
      forever begin
         @(posedge rst);
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL reset_rec: no expectation queued, got an=%h seg=%h dp=%b", an, seg, dp);
         end else begin
            e = exp_q.pop_front();
            if (an !== e.an || seg !== e.seg || dp !== e.dp || e.len != 0) begin
               errors++;
               $display("FAIL reset_async: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b (len %0d)",
                        an, seg, dp, e.an, e.seg, e.dp, e.len);
            end
         end
      end
   end

   // Run monitor plus anode overlap / dead-time properties.
   initial begin
      logic [11:0] run_val;
      logic [11:0] tup;
      int          run_len;
      logic [3:0]  prev_an;
      int          off_cnt;
      bit          seen_on;
      int          lows;
      rec_t        e;
      run_len = 0;
      run_val = '0;
      prev_an = 4'hF;
      off_cnt = 0;
      seen_on = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            run_len = 0;
            prev_an = 4'hF;
            off_cnt = 0;
            seen_on = 0;
         end else begin
            tup = {an, seg, dp};
            if (run_len != 0 && tup !== run_val) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL run_unexpected: got an=%h seg=%h dp=%b len=%0d, expected nothing",
                           run_val[11:8], run_val[7:1], run_val[0], run_len);
               end else begin
                  e = exp_q.pop_front();
                  if (run_val !== {e.an, e.seg, e.dp} || run_len != e.len) begin
                     errors++;
                     $display("FAIL run: got an=%h seg=%h dp=%b len=%0d, expected an=%h seg=%h dp=%b len=%0d",
                              run_val[11:8], run_val[7:1], run_val[0], run_len, e.an, e.seg, e.dp, e.len);
                  end
               end
               run_len = 0;
            end
            run_val = tup;
            run_len++;

            lows = 0;
            for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lows++;
            if (lows > 1) overlap_viol++;
            if (an != 4'hF) begin
               if (prev_an != 4'hF && prev_an != an) dead_viol++;
               if (prev_an == 4'hF && seen_on && off_cnt < 2) dead_viol++;
               seen_on = 1;
               off_cnt = 0;
            end else begin
               off_cnt++;
            end
            prev_an = an;
         end
      end
   end

   initial begin
      rst      = 1'b0;
      digits   = 16'h0000;
      dp_mask  = 4'h0;
      blink_en = 4'h0;
      blink    = 1'b1;
      #2;
      push(4'hF, 7'h7F, 1'b1, 0);
      rst = 1'b1;
      step(3);

      // Scan 1234 with dp on digit 1; reset lands mid digit 2 of the second scan.
      digits  = 16'h1234;
      dp_mask = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         push_off(); push(4'hE, 7'h19, 1'b1, 8);
         push_off(); push(4'hD, 7'h30, 1'b0, 8);
         if (k == 0) begin
            push_off(); push(4'hB, 7'h24, 1'b1, 8);
            push_off(); push(4'h7, 7'h79, 1'b1, 8);
         end
      end
      push_off();
      rst = 1'b0;
      step(65);
      push(4'hF, 7'h7F, 1'b1, 0);
      rst = 1'b1;
      step(3);

      // Mid-slot change, decode 8/9, and F blank glyph while scanning.
      digits  = 16'h0000;
      dp_mask = 4'h0;
      push_off(); push(4'hE, 7'h40, 1'b1, 8);
      push_off(); push(4'hD, 7'h00, 1'b1, 8);
      push_off(); push(4'hB, 7'h10, 1'b1, 8);
      push_off(); push(4'h7, 7'h7F, 1'b1, 8);
      push_off(); push(4'hE, 7'h7F, 1'b1, 8);
      push_off();
      rst = 1'b0;
      step(6);
      digits = 16'h9988;
      step(19);
      digits = 16'hFFFF;
      step(30);
      push(4'hF, 7'h7F, 1'b1, 0);
      rst = 1'b1;
      step(3);

      // Blink on digits 0 and 2; dp enabled everywhere to show dp forced off.
      digits   = 16'h5678;
      dp_mask  = 4'hF;
      blink_en = 4'b0101;
      blink    = 1'b1;
      push_off(); push(4'hE, 7'h00, 1'b0, 5); push(4'hE, 7'h7F, 1'b1, 3);
      push_off(); push(4'hD, 7'h78, 1'b0, 8);
      push_off(); push(4'hB, 7'h7F, 1'b1, 8);
      push_off(); push(4'h7, 7'h12, 1'b0, 8);
      push_off(); push(4'hE, 7'h7F, 1'b1, 5); push(4'hE, 7'h00, 1'b0, 3);
      push_off(); push(4'hD, 7'h78, 1'b0, 8);
      push_off();
      rst = 1'b0;
      step(5);
      blink = 1'b0;
      step(40);
      blink = 1'b1;
      step(20);
      push(4'hF, 7'h7F, 1'b1, 0);
      rst = 1'b1;
      step(3);

      // Letter glyphs A, b, E, d.
      digits   = 16'hDCBA;
      dp_mask  = 4'h0;
      blink_en = 4'h0;
      push_off(); push(4'hE, 7'h08, 1'b1, 8);
      push_off(); push(4'hD, 7'h03, 1'b1, 8);
      push_off(); push(4'hB, 7'h06, 1'b1, 8);
      push_off(); push(4'h7, 7'h21, 1'b1, 8);
      push_off();
      rst = 1'b0;
      step(15);
      digits = 16'hDE00;
      step(30);
      push(4'hF, 7'h7F, 1'b1, 0);
      rst = 1'b1;
      step(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expected runs never seen, required 0", exp_q.size());
      end
      checks++;
      if (overlap_viol != 0) begin
         errors++;
         $display("FAIL anode_overlap: %0d cycles with >1 anode low, required 0", overlap_viol);
      end
      checks++;
      if (dead_viol != 0) begin
         errors++;
         $display("FAIL dead_time: %0d anode changes without 2 off cycles, required 0", dead_viol);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
